// File: rtl/prog_ctr.sv
// Program counter and branch-resolution stage: latches the ALU Zero flag,
// resolves jumps/branches against it and runs the Start/Done program handshake.
module prog_ctr #(
    parameter int              PC_W       = 10,
    parameter int              CNT_W      = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             Jump,
    input  logic             BranchZ,
    input  logic             BranchNZ,
    input  logic             Rel,
    input  logic [PC_W-1:0]  Target,
    input  logic [7:0]       Offset,
    input  logic             FlagWe,
    input  logic             Zero,
    output logic [PC_W-1:0]  PC,
    output logic             ZFlag,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  off_sext;
    logic [PC_W-1:0]  tgt;
    logic             take;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] cnt_next;

    // Branches look at the flag as registered before this edge, so a FlagWe
    // in the same cycle never influences the decision it sits beside.
    always_comb begin
        off_sext = {{(PC_W-8){Offset[7]}}, Offset};
        tgt      = Rel ? PC + off_sext : Target;
        take     = Jump | (BranchZ & ZFlag) | (BranchNZ & ~ZFlag);
        pc_next  = take ? tgt : PC + PC_W'(1);
        cnt_next = (InstrCnt == '1) ? InstrCnt : InstrCnt + CNT_W'(1);
    end

    // Start/Done handshake: Start is a level request accepted only in IDLE or
    // DONE (ignored while RUN); Done stays high from the retiring Halt until
    // the next accepted Start or Reset, with PC/ZFlag/InstrCnt held for readback.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            PC       <= START_ADDR;
            ZFlag    <= 1'b0;
            InstrCnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state    <= RUN;
                        PC       <= START_ADDR;
                        ZFlag    <= 1'b0;
                        InstrCnt <= '0;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        InstrCnt <= cnt_next;
                        if (FlagWe) ZFlag <= Zero;
                        if (Halt) state <= DONE;
                        else      PC    <= pc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Running   = (state == RUN);
    assign Done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_prog_ctr.sv
// Randomised + directed bench for prog_ctr: a driver pushes the expected
// post-edge outputs from a reference model, a monitor pops and compares.
module tb_prog_ctr;
    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int EXP_W = 3 + CNT_W + PC_W;

    typedef struct packed {
        logic            reset;
        logic            start;
        logic            stall;
        logic            halt;
        logic            jump;
        logic            bz;
        logic            bnz;
        logic            rel;
        logic            flag_we;
        logic            zero;
        logic [PC_W-1:0] target;
        logic [7:0]      offset;
    } stim_t;

    logic             Clk = 1'b0;
    logic             Reset, Start, Stall, Halt, Jump, BranchZ, BranchNZ, Rel;
    logic [PC_W-1:0]  Target;
    logic [7:0]       Offset;
    logic             FlagWe, Zero;
    logic [PC_W-1:0]  PC;
    logic             ZFlag, Running, Done;
    logic [CNT_W-1:0] InstrCnt;
    logic [1:0]       state_dbg;

    logic [EXP_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // reference model: phase 0 = idle, 1 = running, 2 = finished
    int m_phase = 0;
    int m_pc    = 0;
    int m_z     = 0;
    int m_cnt   = 0;

    prog_ctr #(.PC_W(PC_W), .CNT_W(CNT_W), .START_ADDR('0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
        .Jump(Jump), .BranchZ(BranchZ), .BranchNZ(BranchNZ), .Rel(Rel),
        .Target(Target), .Offset(Offset), .FlagWe(FlagWe), .Zero(Zero),
        .PC(PC), .ZFlag(ZFlag), .Running(Running), .Done(Done),
        .InstrCnt(InstrCnt), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 Clk = ~Clk;

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [EXP_W-1:0] model_out();
        logic [PC_W-1:0]  p;
        logic [CNT_W-1:0] c;
        p = PC_W'(m_pc);
        c = CNT_W'(m_cnt);
        return {(m_phase == 1), (m_phase == 2), (m_z != 0), c, p};
    endfunction

    task automatic model_step(input stim_t s);
        int off;
        int tgt;
        bit taken;
        if (s.reset) begin
            m_phase = 0; m_pc = 0; m_z = 0; m_cnt = 0;
        end else if (m_phase != 1) begin
            if (s.start) begin
                m_phase = 1; m_pc = 0; m_z = 0; m_cnt = 0;
            end
        end else if (!s.stall) begin
            off   = s.offset[7] ? int'(s.offset) - 256 : int'(s.offset);
            tgt   = s.rel ? (m_pc + off + 1024) % 1024 : int'(s.target);
            taken = s.jump || (s.bz && m_z != 0) || (s.bnz && m_z == 0);
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (s.flag_we) m_z = s.zero ? 1 : 0;
            if (s.halt)      m_phase = 2;
            else if (taken)  m_pc = tgt;
            else             m_pc = (m_pc + 1) % 1024;
        end
    endtask

    // driver: inputs change on the falling edge, expectation queued with them
    task automatic drive(input stim_t s);
        @(negedge Clk);
        Reset = s.reset; Start = s.start; Stall = s.stall; Halt = s.halt;
        Jump = s.jump; BranchZ = s.bz; BranchNZ = s.bnz; Rel = s.rel;
        Target = s.target; Offset = s.offset; FlagWe = s.flag_we; Zero = s.zero;
        model_step(s);
        exp_q.push_back(model_out());
    endtask

    // monitor / scoreboard: one observation per rising edge, sampled 1 time unit later
    initial begin
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] act_v;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {Running, Done, ZFlag, InstrCnt, PC};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL outputs t=%0t run/done/z/cnt/pc act=%b/%b/%b/%0d/%h exp=%b/%b/%b/%0d/%h",
                             $time, act_v[EXP_W-1], act_v[EXP_W-2], act_v[EXP_W-3],
                             act_v[PC_W +: CNT_W], act_v[PC_W-1:0],
                             exp_v[EXP_W-1], exp_v[EXP_W-2], exp_v[EXP_W-3],
                             exp_v[PC_W +: CNT_W], exp_v[PC_W-1:0]);
                end
            end
        end
    end

    initial begin
        stim_t s;
        Reset = 1'b1; Start = 0; Stall = 0; Halt = 0; Jump = 0; BranchZ = 0;
        BranchNZ = 0; Rel = 0; Target = '0; Offset = '0; FlagWe = 0; Zero = 0;

        s = nop(); s.reset = 1; drive(s); drive(s);
        // start then three plain retirements: PC 1,2,3
        s = nop(); s.start = 1; drive(s);
        s = nop(); repeat (3) drive(s);
        // flag set, then BranchZ absolute
        s = nop(); s.flag_we = 1; s.zero = 1; drive(s);
        s = nop(); s.bz = 1; s.target = 10'h155; drive(s);
        // flag set, then BranchNZ falls through
        s = nop(); s.flag_we = 1; s.zero = 1; drive(s);
        s = nop(); s.bnz = 1; s.target = 10'h0AA; drive(s);
        // clear flag, then same-cycle write must not steer the branch
        s = nop(); s.flag_we = 1; s.zero = 0; drive(s);
        s = nop(); s.flag_we = 1; s.zero = 1; s.bz = 1; s.target = 10'h200; drive(s);
        // PC wrap and negative relative offset
        s = nop(); s.jump = 1; s.target = 10'h3FF; drive(s);
        s = nop(); drive(s);
        s = nop(); s.jump = 1; s.target = 10'h002; drive(s);
        s = nop(); s.rel = 1; s.offset = 8'hFB; s.bz = 1; s.bnz = 1; drive(s);
        // stall with jump for three cycles, then release
        s = nop(); s.stall = 1; s.jump = 1; s.target = 10'h123; s.flag_we = 1; s.zero = 0;
        repeat (3) drive(s);
        s.stall = 0; drive(s);
        // halt at 7, hold in DONE, restart from DONE
        s = nop(); s.jump = 1; s.target = 10'h007; drive(s);
        s = nop(); s.halt = 1; s.flag_we = 1; s.zero = 1; drive(s);
        s = nop(); s.jump = 1; s.target = 10'h055; drive(s); drive(s);
        s = nop(); s.start = 1; drive(s);
        s = nop(); s.start = 1; drive(s); drive(s);
        // reset mid-run
        s = nop(); s.reset = 1; drive(s);
        s = nop(); drive(s);

        for (int i = 0; i < 3000; i++) begin
            s.reset   = ($urandom_range(0, 63) == 0);
            s.start   = ($urandom_range(0, 7) == 0);
            s.stall   = ($urandom_range(0, 3) == 0);
            s.halt    = ($urandom_range(0, 15) == 0);
            s.jump    = ($urandom_range(0, 7) == 0);
            s.bz      = ($urandom_range(0, 3) == 0);
            s.bnz     = ($urandom_range(0, 3) == 0);
            s.rel     = 1'($urandom_range(0, 1));
            s.flag_we = 1'($urandom_range(0, 1));
            s.zero    = 1'($urandom_range(0, 1));
            s.target  = PC_W'($urandom);
            s.offset  = 8'($urandom);
            drive(s);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
